booth_r4_mult_seq: RTL and testbench

Parametrised, iterative radix-4 Booth multiplier with valid/ready handshakes and a per-operation signed/unsigned mode. It produces one Booth digit per clock and delivers a full 2N-bit product. It is the mantissa multiplier of the floating-point multiplier datapath; at N=24 it consumes 24-bit significands including the hidden bit. It replaces the fixed 12-bit unsigned radix-4 block.

---
 rtl/booth_r4_mult_seq_pkg.sv | 34 +++
 rtl/booth_r4_mult_seq_encoder.sv | 33 +++
 rtl/booth_r4_mult_seq.sv | 118 +++++++++++
 tb/tb_booth_r4_mult_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/booth_r4_mult_seq_pkg.sv
// booth_pkg: shared types and the radix-4 Booth digit decode for the
// iterative mantissa multiplier.
//   booth_state_e : controller state encoding (IDLE/BUSY/DONE)
//   booth_digit_e : recoded Booth digit (0, +M, +2M, -M, -2M)
//   booth_decode  : maps {q[1], q[0], q_-1} to a Booth digit
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } booth_state_e;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    P1   = 3'd1,
    P2   = 3'd2,
    M1   = 3'd3,
    M2   = 3'd4
  } booth_digit_e;

  function automatic booth_digit_e booth_decode(input logic [2:0] triplet);
    booth_digit_e d;
    case (triplet)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_mult_seq_encoder.sv
// booth_r4_encoder: combinational partial-product generator for one
// radix-4 Booth digit.
//   triplet_i : {q[1], q[0], q_-1} from the multiplier shift register
//   m_i       : multiplicand, already extended to N+2 bits
//   pp_o      : selected multiple (0, +/-M, +/-2M) as an N+4-bit signed value
module booth_r4_encoder
  import booth_pkg::*;
#(
  parameter int N = 24
) (
  input  logic [2:0]   triplet_i,
  input  logic [N+1:0] m_i,
  output logic [N+3:0] pp_o
);

  logic [N+3:0] m_ext;
  logic [N+3:0] m2_ext;

  assign m_ext  = {{2{m_i[N+1]}}, m_i};
  assign m2_ext = {m_i[N+1], m_i, 1'b0};

  always_comb begin
    pp_o = '0;
    case (booth_decode(triplet_i))
      P1:      pp_o = m_ext;
      P2:      pp_o = m2_ext;
      M1:      pp_o = -m_ext;
      M2:      pp_o = -m2_ext;
      default: pp_o = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// booth_r4_mult_seq: iterative radix-4 Booth multiplier, one Booth digit
// per clock, N/2+1 iterations per operation, full 2N-bit product.
//   clk, rstn            : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake; M, Q, is_signed sampled on accept
//   out_valid / out_ready: result handshake; R held stable while out_valid
//   R                    : 2N-bit product (exact in signed and unsigned mode)
//   busy                 : operation in progress (BUSY or DONE)
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// BUSY  | one Booth iteration per cycle
// DONE  | product valid in R, waiting for out_ready
module booth_r4_mult_seq
  import booth_pkg::*;
#(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   M,
  input  logic [N-1:0]   Q,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] R,
  output logic           busy
);

  localparam int ITER = N / 2 + 1;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  booth_state_e   state_q, state_d;
  logic [N+1:0]   m_q, m_d;
  logic [N+3:0]   a_q, a_d;
  logic [N+1:0]   q_q, q_d;
  logic           qm1_q, qm1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] r_q, r_d;

  logic [N+3:0]   pp;
  logic [N+3:0]   a_sum;

  booth_r4_encoder #(.N(N)) u_enc (
    .triplet_i ({q_q[1:0], qm1_q}),
    .m_i       (m_q),
    .pp_o      (pp)
  );

  assign a_sum = a_q + pp;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Two extra bits let unsigned operands be treated as signed.
          m_d     = {{2{is_signed & M[N-1]}}, M};
          q_d     = {{2{is_signed & Q[N-1]}}, Q};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Arithmetic shift of {A, Q, q_-1} right by two after the add.
        a_d   = {{2{a_sum[N+3]}}, a_sum[N+3:2]};
        q_d   = {a_sum[1:0], q_q[N+1:2]};
        qm1_d = q_q[1];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Low N+2 bits of the product sit in Q, the rest in the bottom of A.
          r_d     = {a_d[N-3:0], q_d};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign R         = r_q;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
// Directed bench for booth_r4_mult_seq at N=12 and N=24.
module tb_booth_r4_mult_seq;

  logic clk;
  logic rstn;

  // N = 12 instance
  logic        in_valid_a, in_ready_a, is_signed_a, out_valid_a, out_ready_a, busy_a;
  logic [11:0] M_a, Q_a;
  logic [23:0] R_a;

  // N = 24 instance
  logic        in_valid_b, in_ready_b, is_signed_b, out_valid_b, out_ready_b, busy_b;
  logic [23:0] M_b, Q_b;
  logic [47:0] R_b;

  int nvec;
  int nerr;

  booth_r4_mult_seq #(.N(12)) dut_a (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .M(M_a), .Q(Q_a), .is_signed(is_signed_a), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .R(R_a), .busy(busy_a)
  );

  booth_r4_mult_seq #(.N(24)) dut_b (
    .clk(clk), .rstn(rstn), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .M(M_b), .Q(Q_b), .is_signed(is_signed_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .R(R_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // ---------------- N = 12 helpers ----------------
  task automatic start12(input logic [11:0] m, input logic [11:0] q, input logic s);
    int w;
    w = 0;
    while (in_ready_a !== 1'b1 && w < 40) begin tick(); w++; end
    chk("a in_ready before accept", {63'd0, in_ready_a}, 64'd1);
    M_a = m; Q_a = q; is_signed_a = s; in_valid_a = 1'b1;
    tick();
    // Operands change right after the accept edge; they must not matter.
    in_valid_a = 1'b0; M_a = ~m; Q_a = 12'($urandom); is_signed_a = ~s;
  endtask

  task automatic wait_done12(output int lat);
    lat = 0;
    do begin tick(); lat++; end while (out_valid_a !== 1'b1 && lat < 40);
  endtask

  task automatic op12(input logic [11:0] m, input logic [11:0] q, input logic s,
                      input logic [23:0] exp, input string tag);
    int lat;
    start12(m, q, s);
    wait_done12(lat);
    chk({tag, " latency"}, 64'(lat), 64'd7);
    chk({tag, " R"}, {40'd0, R_a}, {40'd0, exp});
    out_ready_a = 1'b1;
    tick();
    out_ready_a = 1'b0;
    chk({tag, " release"}, {61'd0, out_valid_a, in_ready_a, busy_a}, 64'b010);
  endtask

  // ---------------- N = 24 helpers ----------------
  task automatic op24(input logic [23:0] m, input logic [23:0] q, input logic s,
                      input logic [47:0] exp, input string tag, input int rdy_gap);
    int lat;
    int w;
    w = 0;
    while (in_ready_b !== 1'b1 && w < 40) begin tick(); w++; end
    chk({tag, " in_ready"}, {63'd0, in_ready_b}, 64'd1);
    M_b = m; Q_b = q; is_signed_b = s; in_valid_b = 1'b1;
    tick();
    in_valid_b = 1'b0; M_b = 24'($urandom); Q_b = 24'($urandom); is_signed_b = ~s;
    lat = 0;
    do begin tick(); lat++; end while (out_valid_b !== 1'b1 && lat < 60);
    chk({tag, " latency"}, 64'(lat), 64'd13);
    repeat (rdy_gap) tick();
    chk({tag, " R"}, {16'd0, R_b}, {16'd0, exp});
    out_ready_b = 1'b1;
    tick();
    out_ready_b = 1'b0;
  endtask

  initial begin
    logic [23:0] m24, q24;
    logic        s24;
    logic [47:0] e24;
    nvec = 0;
    nerr = 0;
    rstn = 1'b0;
    in_valid_a = 0; M_a = '0; Q_a = '0; is_signed_a = 0; out_ready_a = 0;
    in_valid_b = 0; M_b = '0; Q_b = '0; is_signed_b = 0; out_ready_b = 0;
    #12;
    chk("reset outputs", {37'd0, out_valid_a, in_ready_a, busy_a, R_a}, {37'd0, 3'b010, 24'd0});
    chk("reset outputs b", {13'd0, out_valid_b, in_ready_b, busy_b, R_b}, {13'd0, 3'b010, 48'd0});
    @(negedge clk);
    rstn = 1'b1;

    // N = 12 directed vectors
    op12(12'h071, 12'h009, 1'b0, 24'h0003F9, "u 071x009");
    op12(12'hFFF, 12'hFFF, 1'b0, 24'hFFE001, "u FFFxFFF");
    op12(12'hFFF, 12'hFFF, 1'b1, 24'h000001, "s FFFxFFF");
    op12(12'h800, 12'h800, 1'b1, 24'h400000, "s 800x800");
    op12(12'h800, 12'h7FF, 1'b1, 24'hC00800, "s 800x7FF");
    op12(12'h000, 12'h800, 1'b1, 24'h000000, "s 000x800");

    // Backpressure in DONE with a competing request on in_valid
    begin
      int lat;
      start12(12'h123, 12'h045, 1'b0);
      wait_done12(lat);
      chk("bp latency", 64'(lat), 64'd7);
      in_valid_a = 1'b1; M_a = 12'h00A; Q_a = 12'h00B; is_signed_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
        chk("bp hold", {37'd0, out_valid_a, busy_a, in_ready_a, R_a},
            {37'd0, 3'b110, 24'h004E6F});
        tick();
      end
      out_ready_a = 1'b1;
      tick();
      out_ready_a = 1'b0;
      in_valid_a  = 1'b0;
      chk("bp back to idle", {61'd0, out_valid_a, in_ready_a, busy_a}, 64'b010);
    end
    op12(12'h00A, 12'h00B, 1'b0, 24'h00006E, "u 00Ax00B");

    // Reset in the middle of an operation
    start12(12'h071, 12'h009, 1'b0);
    repeat (3) tick();
    chk("mid-op busy", {63'd0, busy_a}, 64'd1);
    rstn = 1'b0;
    #1;
    chk("async reset", {37'd0, out_valid_a, in_ready_a, busy_a, R_a}, {37'd0, 3'b010, 24'd0});
    @(negedge clk);
    rstn = 1'b1;
    op12(12'h0FF, 12'h0FF, 1'b0, 24'h00FE01, "u 0FFx0FF after reset");

    // N = 24 directed corners
    op24(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, "b u max", 0);
    op24(24'hFFFFFF, 24'hFFFFFF, 1'b1, 48'h000000000001, "b s -1x-1", 1);
    op24(24'h800000, 24'h800000, 1'b1, 48'h400000000000, "b s minxmin", 0);
    op24(24'h800000, 24'hFFFFFF, 1'b0, 48'h7FFFFF800000, "b u 800000xFFFFFF", 2);

    // N = 24 operands with random mode and handshake gaps
    for (int i = 0; i < 40; i++) begin
      m24 = 24'($urandom);
      q24 = 24'($urandom);
      s24 = 1'($urandom);
      e24 = {{24{s24 & m24[23]}}, m24} * {{24{s24 & q24[23]}}, q24};
      repeat ($urandom_range(0, 3)) tick();
      op24(m24, q24, s24, e24, "b rand", $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
